pipe_ctrl: RTL

//   Pipeline sequencer for the 5-stage core: produces per-stage stall vector and flush.

---
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core.
// Produces the per-stage stall vector and the flush strobe. It detects load-use
// hazards on the two ID read ports, holds the pipeline while a multi-cycle EX
// operation runs, and sequences flush windows.
// stall_o, flush_o and mc_done_o are combinational (zero latency). The state,
// the cycle counter and the stall statistics counter are registered.
module pipe_ctrl #(
    parameter int MC_CYCLES    = 5,   // total EX occupancy of a multi-cycle op (>= 2)
    parameter int FLUSH_CYCLES = 1,   // flush_o high time per request (>= 1)
    parameter int CNT_W        = 8    // must hold max(MC_CYCLES, FLUSH_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_reg1_read_i,
    input  logic [4:0]  id_reg1_addr_i,
    input  logic        id_reg2_read_i,
    input  logic [4:0]  id_reg2_addr_i,
    input  logic        ex_is_load_i,
    input  logic        ex_wreg_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        ex_mc_start_i,
    input  logic        flush_req_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        mc_done_o,
    output logic        busy_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MC_BUSY = 2'b01,
        FLUSH   = 2'b10
    } state_t;

    // Stall patterns: a multi-cycle op freezes everything up to and including
    // EX/MEM; a load-use hazard freezes pc, IF/ID and ID/EX so a bubble enters EX.
    localparam logic [5:0] STALL_MC = 6'b001111;
    localparam logic [5:0] STALL_LU = 6'b000111;

    // Counter reload values. The first stalled / flushed cycle happens in the
    // requesting cycle itself, so the counter covers the remaining cycles.
    localparam logic [CNT_W-1:0] MC_LOAD    = CNT_W'(MC_CYCLES - 2);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    // A single-cycle flush is completed by the requesting cycle alone, so the
    // FLUSH state is only entered when more than one cycle is needed.
    localparam state_t FLUSH_ENTRY = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      stall_cnt_reg;

    logic [5:0]       stall_next;
    logic             flush_next;
    logic             done_next;

    // Load-use detection: one comparator per ID read port.
    logic [1:0]       rd_en;
    logic [4:0]       rd_addr [2];
    logic [1:0]       port_hit;
    logic             ex_load_dest;
    logic             load_hit;

    assign rd_en      = {id_reg2_read_i, id_reg1_read_i};
    assign rd_addr[0] = id_reg1_addr_i;
    assign rd_addr[1] = id_reg2_addr_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_hit[gi] = rd_en[gi] && (rd_addr[gi] == ex_waddr_i);
        end
    endgenerate

    // $0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign ex_load_dest = ex_is_load_i && ex_wreg_i && (ex_waddr_i != 5'd0);
    assign load_hit     = ex_load_dest && (|port_hit);

    // Next-state, counter and raw output decode; flush beats multi-cycle beats load-use.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_next = '0;
        flush_next = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (flush_req_i) begin
                    flush_next = 1'b1;
                    cnt_next   = FLUSH_LOAD;
                    state_next = FLUSH_ENTRY;
                end else if (ex_mc_start_i) begin
                    stall_next = STALL_MC;
                    cnt_next   = MC_LOAD;
                    state_next = MC_BUSY;
                end else if (load_hit) begin
                    stall_next = STALL_LU;
                end
            end

            MC_BUSY: begin
                // load_hit and ex_mc_start_i are irrelevant here: ID is already held.
                if (flush_req_i) begin
                    flush_next = 1'b1;
                    cnt_next   = FLUSH_LOAD;
                    state_next = FLUSH_ENTRY;
                end else if (cnt_reg != '0) begin
                    stall_next = STALL_MC;
                    cnt_next   = cnt_reg - 1'b1;
                end else begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            FLUSH: begin
                flush_next = 1'b1;
                if (flush_req_i) begin
                    // A fresh request restarts the whole window.
                    cnt_next   = FLUSH_LOAD;
                    state_next = FLUSH_ENTRY;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and cycle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outputs are forced low for as long as reset is held, independent of inputs.
    assign stall_o   = rst ? 6'b000000 : stall_next;
    assign flush_o   = !rst && flush_next;
    assign mc_done_o = !rst && done_next;
    assign busy_o    = !rst && (state_reg != IDLE);
    assign state_o   = state_reg;

    // Count every cycle in which any stage is held; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (|stall_o) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;

endmodule
